// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe-gap generator.
// Holds the reset height tables, the LFSR tap mask, the coordinate width
// and the slot record type used by the top module.
package pipe_pkg;

    localparam int YW    = 10;
    localparam int DEF_N = 5;

    // Reset gap table, repeated every DEF_N slots when NUM_PIPES > DEF_N.
    localparam int DEF_T [DEF_N] = '{50, 100, 150, 110, 80};
    localparam int DEF_B [DEF_N] = '{250, 220, 230, 270, 280};

    // Fibonacci taps 16,14,13,11 on a right-shifting register map to
    // state bits 0,2,3,5; the feedback bit enters at bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    typedef struct packed {
        logic [YW-1:0] top;
        logic [YW-1:0] bot;
        logic [YW-1:0] coin_y;
        logic          coin_vld;
    } slot_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/pipe_lfsr16.sv
// 16-bit free-running Fibonacci LFSR.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset, loads SEED
//   o_state  out  current 16-bit register state
module pipe_lfsr16
    import pipe_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEED;
        end else begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/pipe_gap_gen.sv
// Registered generator of pipe-gap and coin Y coordinates for NUM_PIPES
// on-screen obstacles. The slot table shifts toward slot 0 on each advance;
// the incoming slot is either the outgoing one (mode 0, rotation) or a
// random gap from the LFSR whose height shrinks with difficulty (mode 1).
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   mode       in   0 = rotate table, 1 = random gaps (sampled on advance)
//   advance    in   1-cycle pulse, slot 0 leaves the screen
//   coin_take  in   1-cycle pulse, coin in slot coin_idx collected
//   coin_idx   in   slot index for coin_take (pre-shift numbering)
//   y_top      out  gap top edges, slot k at [k*YW +: YW]
//   y_bot      out  gap bottom edges
//   y_coin     out  coin Y coordinates
//   coin_vld   out  per-slot coin present flags
//   level      out  difficulty level
module pipe_gap_gen
    import pipe_pkg::*;
#(
    parameter int          NUM_PIPES   = 5,
    parameter int          YW          = 10,
    parameter int          SCREEN_H    = 300,
    parameter int          TOP_MIN     = 40,
    parameter int          BOT_MARGIN  = 20,
    parameter int          GAP_START   = 200,
    parameter int          GAP_MIN     = 100,
    parameter int          GAP_STEP    = 10,
    parameter int          LEVEL_EVERY = 8,
    parameter int          LEVEL_MAX   = 15,
    parameter int          COIN_OFS    = 30,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic                    advance,
    input  logic                    coin_take,
    input  logic [2:0]              coin_idx,
    output logic [NUM_PIPES*YW-1:0] y_top,
    output logic [NUM_PIPES*YW-1:0] y_bot,
    output logic [NUM_PIPES*YW-1:0] y_coin,
    output logic [NUM_PIPES-1:0]    coin_vld,
    output logic [3:0]              level
);

    localparam int CNT_W = (LEVEL_EVERY > 2) ? $clog2(LEVEL_EVERY) : 1;

    // Elaboration-time parameter sanity checks. The largest gap gives the
    // smallest tmax; the smallest gap gives the lowest bottom edge.
    if (NUM_PIPES < 2 || NUM_PIPES > 8) begin : g_bad_num
        $error("pipe_gap_gen: NUM_PIPES must be in 2..8");
    end
    if (YW != pipe_pkg::YW) begin : g_bad_yw
        $error("pipe_gap_gen: YW must match pipe_pkg::YW");
    end
    if (GAP_MIN > GAP_START) begin : g_bad_gap
        $error("pipe_gap_gen: GAP_MIN exceeds GAP_START");
    end
    if (TOP_MIN > SCREEN_H - BOT_MARGIN - GAP_START) begin : g_bad_tmax
        $error("pipe_gap_gen: TOP_MIN exceeds worst-case tmax");
    end
    if (SCREEN_H - BOT_MARGIN >= (1 << YW)) begin : g_bad_bot
        $error("pipe_gap_gen: bottom edge does not fit in YW bits");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("pipe_gap_gen: LFSR_SEED must be nonzero");
    end

    localparam logic [YW:0] P_SCREEN_H   = (YW+1)'(SCREEN_H);
    localparam logic [YW:0] P_BOT_MARGIN = (YW+1)'(BOT_MARGIN);
    localparam logic [YW:0] P_TOP_MIN    = (YW+1)'(TOP_MIN);
    localparam logic [YW:0] P_GAP_START  = (YW+1)'(GAP_START);
    localparam logic [YW:0] P_GAP_MIN    = (YW+1)'(GAP_MIN);
    localparam logic [YW:0] P_GAP_STEP   = (YW+1)'(GAP_STEP);
    localparam logic [YW:0] P_COIN_OFS   = (YW+1)'(COIN_OFS);

    function automatic logic [YW-1:0] coin_of(input logic [YW-1:0] bot);
        logic [YW:0] t;
        t = {1'b0, bot} - P_COIN_OFS;
        return t[YW-1:0];
    endfunction

    function automatic slot_t reset_slot(input int k);
        slot_t s;
        s.top      = YW'(DEF_T[k % DEF_N]);
        s.bot      = YW'(DEF_B[k % DEF_N]);
        s.coin_y   = coin_of(s.bot);
        s.coin_vld = 1'b1;
        return s;
    endfunction

    logic [15:0]          w_lfsr;
    logic                 w_lfsr_unused;
    slot_t                r_slot [NUM_PIPES];
    logic [3:0]           r_level;
    logic [CNT_W-1:0]     r_adv_cnt;
    logic [NUM_PIPES-1:0] w_vld_clr;
    slot_t                w_new;
    logic [YW:0]          w_red;
    logic [YW:0]          w_gap;
    logic [YW:0]          w_tmax;
    logic [YW:0]          w_top_raw;
    logic [YW:0]          w_top;
    logic [YW:0]          w_bot;

    pipe_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .o_state (w_lfsr)
    );

    // Only the low byte feeds the gap position.
    assign w_lfsr_unused = ^w_lfsr[15:8];

    // Coin clears act on the pre-shift numbering, so they are folded in
    // before the shift picks up its source flags.
    always_comb begin
        w_vld_clr = '0;
        for (int k = 0; k < NUM_PIPES; k++) begin
            w_vld_clr[k] = r_slot[k].coin_vld & ~(coin_take && (coin_idx == 3'(k)));
        end
    end

    // Incoming slot for the tail of the table.
    always_comb begin
        w_red = (YW+1)'(r_level) * P_GAP_STEP;
        // Compare before subtracting so the gap never wraps below GAP_MIN.
        if (w_red >= P_GAP_START - P_GAP_MIN) begin
            w_gap = P_GAP_MIN;
        end else begin
            w_gap = P_GAP_START - w_red;
        end
        w_tmax    = P_SCREEN_H - P_BOT_MARGIN - w_gap;
        w_top_raw = P_TOP_MIN + (YW+1)'(w_lfsr[7:0]);
        w_top     = (w_top_raw > w_tmax) ? w_tmax : w_top_raw;
        w_bot     = w_top + w_gap;

        w_new = '0;
        if (mode) begin
            w_new.top = w_top[YW-1:0];
            w_new.bot = w_bot[YW-1:0];
        end else begin
            w_new.top = r_slot[0].top;
            w_new.bot = r_slot[0].bot;
        end
        w_new.coin_y   = coin_of(w_new.bot);
        w_new.coin_vld = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                r_slot[k] <= reset_slot(k);
            end
            r_level   <= '0;
            r_adv_cnt <= '0;
        end else if (advance) begin
            for (int k = 0; k < NUM_PIPES - 1; k++) begin
                r_slot[k].top      <= r_slot[k+1].top;
                r_slot[k].bot      <= r_slot[k+1].bot;
                r_slot[k].coin_y   <= r_slot[k+1].coin_y;
                r_slot[k].coin_vld <= w_vld_clr[k+1];
            end
            r_slot[NUM_PIPES-1] <= w_new;
            if (r_adv_cnt == CNT_W'(LEVEL_EVERY - 1)) begin
                r_adv_cnt <= '0;
                if (r_level != 4'(LEVEL_MAX)) begin
                    r_level <= r_level + 4'd1;
                end
            end else begin
                r_adv_cnt <= r_adv_cnt + CNT_W'(1);
            end
        end else begin
            for (int k = 0; k < NUM_PIPES; k++) begin
                r_slot[k].coin_vld <= w_vld_clr[k];
            end
        end
    end

    always_comb begin
        y_top    = '0;
        y_bot    = '0;
        y_coin   = '0;
        coin_vld = '0;
        for (int k = 0; k < NUM_PIPES; k++) begin
            y_top[k*YW +: YW]  = r_slot[k].top;
            y_bot[k*YW +: YW]  = r_slot[k].bot;
            y_coin[k*YW +: YW] = r_slot[k].coin_y;
            coin_vld[k]        = r_slot[k].coin_vld;
        end
    end

    assign level = r_level;

endmodule

// File: tb/tb_pipe_gap_gen.sv
module tb_pipe_gap_gen;

    localparam int N  = 5;
    localparam int YW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       = 1'b1;
    logic          mode      = 1'b0;
    logic          advance   = 1'b0;
    logic          coin_take = 1'b0;
    logic [2:0]    coin_idx  = 3'd0;
    logic [N*YW-1:0] y_top, y_bot, y_coin;
    logic [N-1:0]    coin_vld;
    logic [3:0]      level;

    pipe_gap_gen dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .advance   (advance),
        .coin_take (coin_take),
        .coin_idx  (coin_idx),
        .y_top     (y_top),
        .y_bot     (y_bot),
        .y_coin    (y_coin),
        .coin_vld  (coin_vld),
        .level     (level)
    );

    typedef struct packed {
        logic [N*YW-1:0] top;
        logic [N*YW-1:0] bot;
        logic [N*YW-1:0] coin;
        logic [N-1:0]    vld;
        logic [3:0]      lvl;
    } exp_t;

    exp_t sb_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // ---------------- reference model ----------------
    int   m_top[$];
    int   m_bot[$];
    int   m_coin[$];
    bit   m_vld[$];
    int   m_adv;
    logic [15:0] m_lfsr;
    int   def_t [5] = '{50, 100, 150, 110, 80};
    int   def_b [5] = '{250, 220, 230, 270, 280};

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        bit b;
        b = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {b, s[15:1]};
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic void model_reset();
        m_top.delete(); m_bot.delete(); m_coin.delete(); m_vld.delete();
        for (int k = 0; k < N; k++) begin
            m_top.push_back(def_t[k % 5]);
            m_bot.push_back(def_b[k % 5]);
            m_coin.push_back(def_b[k % 5] - 30);
            m_vld.push_back(1'b1);
        end
        m_adv  = 0;
        m_lfsr = 16'hACE1;
    endfunction

    function automatic int model_level();
        return imin(15, m_adv / 8);
    endfunction

    function automatic void model_cycle(input bit r, input bit md, input bit adv,
                                        input bit tk, input int idx);
        int nt, nb, gap;
        if (r) begin
            model_reset();
            return;
        end
        if (tk && idx < N) m_vld[idx] = 1'b0;
        if (adv) begin
            if (!md) begin
                nt = m_top[0];
                nb = m_bot[0];
            end else begin
                gap = imax(100, 200 - model_level() * 10);
                nt  = imin(40 + int'(m_lfsr[7:0]), 300 - 20 - gap);
                nb  = nt + gap;
            end
            void'(m_top.pop_front());
            void'(m_bot.pop_front());
            void'(m_coin.pop_front());
            void'(m_vld.pop_front());
            m_top.push_back(nt);
            m_bot.push_back(nb);
            m_coin.push_back(nb - 30);
            m_vld.push_back(1'b1);
            m_adv++;
        end
        m_lfsr = ref_lfsr(m_lfsr);
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e = '0;
        for (int k = 0; k < N; k++) begin
            e.top[k*YW +: YW]  = YW'(m_top[k]);
            e.bot[k*YW +: YW]  = YW'(m_bot[k]);
            e.coin[k*YW +: YW] = YW'(m_coin[k]);
            e.vld[k]           = m_vld[k];
        end
        e.lvl = 4'(model_level());
        return e;
    endfunction

    // One clock of stimulus; expected post-edge state goes to the scoreboard.
    task automatic step(input bit r, input bit md, input bit adv, input bit tk, input int idx);
        @(negedge clk);
        rst       = r;
        mode      = md;
        advance   = adv;
        coin_take = tk;
        coin_idx  = 3'(idx);
        model_cycle(r, md, adv, tk, idx);
        sb_q.push_back(snap());
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_top",   64'(y_top),    64'(e.top));
                chk("sb_bot",   64'(y_bot),    64'(e.bot));
                chk("sb_coin",  64'(y_coin),   64'(e.coin));
                chk("sb_vld",   64'(coin_vld), 64'(e.vld));
                chk("sb_level", 64'(level),    64'(e.lvl));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N*YW-1:0] tab_t;
        logic [N*YW-1:0] tab_b;
        bit md;
        tab_t = {10'd80, 10'd110, 10'd150, 10'd100, 10'd50};
        tab_b = {10'd280, 10'd270, 10'd230, 10'd220, 10'd250};

        // Reset state
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_top",   64'(y_top), 64'(tab_t));
        chk("rst_bot",   64'(y_bot), 64'(tab_b));
        chk("rst_coin0", 64'(y_coin[9:0]), 64'd220);
        chk("rst_vld",   64'(coin_vld), 64'h1F);
        chk("rst_level", 64'(level), 64'd0);

        // Mode 0 rotation
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0);
            if (i == 0) begin
                chk("rot1_slot0_top", 64'(y_top[9:0]), 64'd100);
                chk("rot1_slot4_top", 64'(y_top[49:40]), 64'd50);
            end
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
        chk("rot5_top", 64'(y_top), 64'(tab_t));
        chk("rot5_bot", 64'(y_bot), 64'(tab_b));

        // Mode 1 single advance from seed
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("rnd1_gap", 64'(y_bot[49:40] - y_top[49:40]), 64'd200);

        // Long run: level saturation and bounds
        for (int i = 0; i < 128; i++) step(0, 1, 1, 0, 0);
        chk("sat_level", 64'(level), 64'd15);
        chk("sat_gap", 64'(y_bot[49:40] - y_top[49:40]), 64'd100);
        for (int k = 0; k < N; k++) begin
            chk("sat_top_min", 64'(y_top[k*YW +: YW] >= 10'd40), 64'd1);
            chk("sat_bot_max", 64'(y_bot[k*YW +: YW] <= 10'd280), 64'd1);
        end

        // coin_take with advance, then out-of-range index
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 2);
        chk("coin_adv_vld", 64'(coin_vld), 64'h1D);
        step(0, 1, 0, 1, 6);
        chk("coin_oob_vld", 64'(coin_vld), 64'h1D);
        step(0, 1, 0, 1, 4);
        chk("coin_take4_vld", 64'(coin_vld), 64'h0D);

        // Reset during an advance at level 3
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 24; i++) step(0, 1, 1, 0, 0);
        chk("lvl3_level", 64'(level), 64'd3);
        step(1, 1, 1, 1, 1);
        chk("rst_adv_level", 64'(level), 64'd0);
        chk("rst_adv_top",   64'(y_top), 64'(tab_t));
        chk("rst_adv_vld",   64'(coin_vld), 64'h1F);

        // Randomized traffic
        md = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) md = ~md;
            step(($urandom_range(0, 149) == 0), md,
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, 7)));
        end

        @(negedge clk);
        rst = 1'b0; advance = 1'b0; coin_take = 1'b0;
        for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
